// File: rtl/tdm_pkg.sv
// Shared constants and frame-position helpers for the TDM serialiser.
package tdm_pkg;

  localparam int unsigned UNDERRUN_CNT_W = 8;

  function automatic int unsigned slot_of(input int unsigned frame_posn,
                                          input int unsigned slot_bits);
    return frame_posn / slot_bits;
  endfunction

  function automatic logic is_slot_start(input int unsigned frame_posn,
                                         input int unsigned slot_bits);
    return (frame_posn % slot_bits) == 0;
  endfunction

endpackage

// File: rtl/tdm_frame_buf.sv
// One-frame input buffer with valid/ready handshake, atomic frame commit and underrun counting.
// TDM_TX_REPEAT_EN: on underrun keep and resend the previous active frame instead of zeros.
module tdm_frame_buf
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                        ck,
  input  logic                        rst,
  input  logic                        frame_start_i,
  input  logic [CHANNELS*WIDTH-1:0]   in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [CHANNELS*WIDTH-1:0]   commit_frame_o,
  output logic [CHANNELS*WIDTH-1:0]   active_o,
  output logic                        underrun_o,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_count_o
);

  localparam int unsigned FrameW = CHANNELS * WIDTH;

  logic [FrameW-1:0]         pending_q, pending_d;
  logic [FrameW-1:0]         active_q, active_d;
  logic [FrameW-1:0]         underrun_frame;
  logic                      full_q, full_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] count_q, count_d;
  logic                      xfer;
  logic                      starve;

  // A frame_start frees the buffer in the same cycle, so a new frame can land immediately.
  assign in_ready_o = !full_q || frame_start_i;
  assign xfer       = in_valid_i && in_ready_o;
  assign starve     = frame_start_i && !full_q;

`ifdef TDM_TX_REPEAT_EN
  assign underrun_frame = active_q;
`else
  assign underrun_frame = '0;
`endif

  // Bypass: the shifter loads channel 0 of this value in the commit cycle itself.
  assign commit_frame_o = full_q ? pending_q : underrun_frame;

  always_comb begin
    pending_d  = pending_q;
    active_d   = active_q;
    full_d     = full_q;
    count_d    = count_q;
    underrun_d = starve;

    if (frame_start_i) begin
      active_d = commit_frame_o;
      full_d   = 1'b0;
    end
    if (xfer) begin
      pending_d = in_data_i;
      full_d    = 1'b1;
    end
    if (starve && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      active_q   <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      active_q   <= active_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
    end
  end

  assign active_o         = active_q;
  assign underrun_o       = underrun_q;
  assign underrun_count_o = count_q;

endmodule

// File: rtl/tdm_tx.sv
// TDM/I2S transmitter: serialises CHANNELS samples MSB first into SLOT_BITS-wide slots.
// TDM_TX_REPEAT_EN (see tdm_frame_buf) retransmits the previous frame on underrun.
module tdm_tx
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned SLOT_BITS  = 32,
  parameter int unsigned FRAME_BITS = $clog2(CHANNELS * SLOT_BITS)
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       en,
  input  logic [FRAME_BITS-1:0]      frame_posn,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       sd,
  output logic                       underrun,
  output logic [UNDERRUN_CNT_W-1:0]  underrun_count
);

  localparam int unsigned ChanW = $clog2(CHANNELS);

  logic                      frame_start;
  logic                      slot_start;
  logic                      on_boundary;
  logic [ChanW-1:0]          slot_idx;
  logic [CHANNELS*WIDTH-1:0] commit_frame;
  logic [CHANNELS*WIDTH-1:0] active_frame;
  logic [WIDTH-1:0]          slot_word;
  logic [WIDTH-1:0]          shift_q, shift_d;
  logic                      sd_q;

  assign slot_idx    = ChanW'(slot_of(32'(frame_posn), SLOT_BITS));
  assign on_boundary = is_slot_start(32'(frame_posn), SLOT_BITS);
  assign frame_start = en && (frame_posn == '0);
  assign slot_start  = en && on_boundary && (frame_posn != '0);
  assign slot_word   = active_frame[slot_idx*WIDTH +: WIDTH];

  tdm_frame_buf #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_frame_buf (
    .ck               (ck),
    .rst              (rst),
    .frame_start_i    (frame_start),
    .in_data_i        (in_data),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .commit_frame_o   (commit_frame),
    .active_o         (active_frame),
    .underrun_o       (underrun),
    .underrun_count_o (underrun_count)
  );

  // Zero fill pads each slot past WIDTH bits; loads happen only on exact boundaries.
  always_comb begin
    shift_d = shift_q;
    if (en) begin
      if (frame_start) begin
        shift_d = commit_frame[WIDTH-1:0];
      end else if (slot_start) begin
        shift_d = slot_word;
      end else begin
        shift_d = shift_q << 1;
      end
    end
  end

  // sd takes the MSB before this cycle's load, giving the one-bit I2S delay.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      sd_q    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      if (en) begin
        sd_q <= shift_q[WIDTH-1];
      end
    end
  end

  assign sd = sd_q;

endmodule
